// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined EX-stage ALU:
// opcodes, controller states and flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;

  // flags = {negative, overflow, carry, zero}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// product is combinational and holds the final value while done is high.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]   count_reg;
  logic               busy_reg;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign busy     = busy_reg;
  // the last iteration's sum is handed out on the same edge it would be stored
  assign done     = busy_reg && (count_reg == LAST);
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + 1'b1;
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_alu_pipe.sv
// EX-stage ALU with valid/ready handshakes on both sides; single-cycle ops
// stream at full rate, multiply stalls the input for WIDTH cycles.
module ex_alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMM_CONST = 55,
  parameter int SHAMT     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       instruction_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags,
  output logic             illegal_op,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] alu_out_reg;
  logic [3:0]       flags_reg;
  logic             illegal_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] last_result_reg;

  logic               accept, mul_start, produce;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum_ext, diff_ext, imm_ext;
  logic [WIDTH-1:0]   imm_val;
  logic [2*WIDTH-1:0] shift_ext;
  logic [WIDTH-1:0]   res_calc;
  logic               carry_calc, ovf_calc, ill_calc;
  logic [3:0]         flags_calc;

  assign in_ready  = (state_reg == ST_IDLE) && !mul_busy && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (instruction_in == OP_MUL);
  assign produce   = (accept && (instruction_in != OP_MUL)) ||
                     ((state_reg == ST_MUL) && mul_done);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign imm_val   = WIDTH'(IMM_CONST);
  assign sum_ext   = {1'b0, a} + {1'b0, b};
  assign diff_ext  = {1'b0, a} - {1'b0, b};
  assign imm_ext   = {1'b0, a} + {1'b0, imm_val};
  assign shift_ext = {{WIDTH{1'b0}}, last_result_reg} << SHAMT;

  always_comb begin
    res_calc   = '0;
    carry_calc = 1'b0;
    ovf_calc   = 1'b0;
    ill_calc   = 1'b0;
    if (state_reg == ST_MUL) begin
      res_calc   = mul_product[WIDTH-1:0];
      carry_calc = |mul_product[2*WIDTH-1:WIDTH];
    end else begin
      case (instruction_in)
        OP_ADD: begin
          res_calc   = sum_ext[WIDTH-1:0];
          carry_calc = sum_ext[WIDTH];
          ovf_calc   = (a[WIDTH-1] == b[WIDTH-1]) && (res_calc[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          res_calc   = diff_ext[WIDTH-1:0];
          carry_calc = diff_ext[WIDTH];
          ovf_calc   = (a[WIDTH-1] != b[WIDTH-1]) && (res_calc[WIDTH-1] != a[WIDTH-1]);
        end
        OP_AND:  res_calc = a & b;
        OP_OR:   res_calc = a | b;
        OP_XOR:  res_calc = a ^ b;
        OP_PASS: res_calc = a;
        OP_ADDI: begin
          res_calc   = imm_ext[WIDTH-1:0];
          carry_calc = imm_ext[WIDTH];
          ovf_calc   = (a[WIDTH-1] == imm_val[WIDTH-1]) && (res_calc[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SHL: begin
          res_calc   = shift_ext[WIDTH-1:0];
          carry_calc = |shift_ext[2*WIDTH-1:WIDTH];
        end
        OP_MUL:  res_calc = '0;
        default: begin
          res_calc = last_result_reg;
          ill_calc = 1'b1;
        end
      endcase
    end

    flags_calc = 4'b0000;
    if (!ill_calc) begin
      flags_calc[FLAG_N] = res_calc[WIDTH-1];
      flags_calc[FLAG_V] = ovf_calc;
      flags_calc[FLAG_C] = carry_calc;
      flags_calc[FLAG_Z] = (res_calc == '0);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (mul_start) state_next = ST_MUL;
      ST_MUL:  if (mul_done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      alu_out_reg     <= '0;
      flags_reg       <= 4'b0000;
      illegal_reg     <= 1'b0;
      out_valid_reg   <= 1'b0;
      last_result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (produce) begin
        alu_out_reg     <= res_calc;
        flags_reg       <= flags_calc;
        illegal_reg     <= ill_calc;
        last_result_reg <= res_calc;
      end
      // a new result replaces a consumed one without a bubble
      out_valid_reg <= produce || (out_valid_reg && !out_ready);
    end
  end

  assign alu_out    = alu_out_reg;
  assign flags      = flags_reg;
  assign illegal_op = illegal_reg;
  assign out_valid  = out_valid_reg;

endmodule

// File: doc/ex_alu_pipe.md
EX_ALU_PIPE -- requirements
Module: ex_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and result (>= 8).
REQ-002 Parameter IMM_CONST, default 55, constant added by opcode 1000.
REQ-003 Parameter SHAMT, default 3, left-shift amount for opcode 1001.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 instruction_in  input  4  opcode.
REQ-009 in_valid  input  1  operands/opcode valid.
REQ-010 in_ready  output  1  block can accept an operation this cycle.
REQ-011 alu_out  output  WIDTH  registered result.
REQ-012 flags  output  4  {negative, overflow, carry, zero}, registered with alu_out.
REQ-013 illegal_op  output  1  registered; set with a result produced from an undefined opcode.
REQ-014 out_valid  output  1  alu_out/flags/illegal_op valid.
REQ-015 out_ready  input  1  consumer accepts the result.

Function
REQ-016 Accept occurs on a rising edge where in_valid && in_ready.
REQ-017 in_ready SHALL equal (state == IDLE) && (!out_valid || out_ready).
REQ-018 Opcodes: 0001 a+b; 0010 a-b; 0011 a*b (low WIDTH bits); 0100 a&b; 0101 a|b; 0110 a^b; 0111 a; 1000 a+IMM_CONST; 1001 last_result << SHAMT.
REQ-019 Undefined opcodes (0000, 1010-1111) SHALL produce result = last_result, flags = 0000, illegal_op = 1.
REQ-020 Non-multiply ops: result and out_valid SHALL be registered on the accept edge (1-cycle latency).
REQ-021 Multiply: iterative shift-add, one bit per cycle; out_valid SHALL rise on the edge WIDTH cycles after the accept edge; in_ready = 0 meanwhile.
REQ-022 FSM states IDLE, MUL. IDLE->MUL on accepting 0011; MUL->IDLE on the edge that produces the result; all other accepts stay in IDLE.
REQ-023 Output hold: while out_valid && !out_ready, alu_out, flags, illegal_op SHALL remain stable.
REQ-024 out_valid clears on an edge with out_ready = 1 unless a new result is produced on that same edge, in which case it stays 1 with the new data.
REQ-025 last_result register SHALL update to every produced result, including illegal-op results.
REQ-026 zero = (result == 0); negative = result[WIDTH-1], for all defined ops.
REQ-027 carry: add/1000 = carry-out; sub = borrow (a < b unsigned); mul = upper WIDTH bits of full product nonzero; 1001 = any bit shifted out nonzero; else 0.
REQ-028 overflow: signed overflow for add, sub, 1000; 0 for all other ops.
REQ-029 Simultaneous out_ready and new accept in the same cycle SHALL be lossless (full throughput for 1-cycle ops).

Reset
REQ-030 On rst: state = IDLE, alu_out = 0, flags = 0000, illegal_op = 0, out_valid = 0, last_result = 0, multiplier registers cleared.
REQ-031 rst during MUL SHALL abandon the operation with no result produced; in_ready = 1 on the cycle after reset deasserts.
REQ-032 rst has priority over any accept or handshake on the same edge.

Structure
REQ-033 Shared package alu_pkg SHALL hold opcode constants, FSM state type and flag bit indices.
REQ-034 Multiply SHALL be a sub-module alu_mul_iter (start, operands in; busy, done, 2*WIDTH product out), parametrised by WIDTH.

Verification
REQ-035 Reset: assert rst 2 cycles -> out_valid = 0, alu_out = 0, flags = 0000, in_ready = 1.
REQ-036 ADD a=0xFFFFFFFF, b=1 -> next cycle alu_out = 0, zero = 1, carry = 1, overflow = 0; SUB a=0x80000000, b=1 -> 0x7FFFFFFF, overflow = 1.
REQ-037 MUL 7*6 -> alu_out = 42 exactly 32 cycles after accept, in_ready = 0 throughout; MUL 0x10000*0x10000 -> alu_out = 0, carry = 1, zero = 1.
REQ-038 Op 1000 a=0 -> 55; then op 1001 -> 440; then opcode 1111 -> alu_out = 440, illegal_op = 1.
REQ-039 Back-pressure: hold out_ready = 0 for 5 cycles -> result stable, in_ready = 0; raise out_ready with in_valid = 1 -> next result delivered on the following cycle, no drop or duplicate.
REQ-040 Assert rst 10 cycles into MUL -> no out_valid pulse; a following ADD 2+3 yields 5 with 1-cycle latency.
